modal_reg_seq: RTL



---
 rtl/modal_reg_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/modal_reg_seq.sv
// Command-driven sequencer for an 8-bit modal shift/load/logic register.
// It accepts one command over a valid/ready handshake. It then drives the
// register's mode, D and Ser inputs for the number of cycles the command
// needs, and pulses done (with err for illegal or aborted commands).
// Every output is decoded from registered state only.
module modal_reg_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             nRst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_ser,
  input  logic             abort,
  output logic [2:0]       mode,
  output logic [WIDTH-1:0] D,
  output logic             Ser,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_accept;
  logic [CNT_W-1:0] w_count_clamp;

  // cmd_ready is high only in IDLE, so an accept is IDLE plus valid.
  assign w_accept      = (r_state == S_IDLE) && cmd_valid;
  // Counts larger than the datapath would only shift in zeros; cap them.
  assign w_count_clamp = (cmd_count > CNT_MAX) ? CNT_MAX : cmd_count;

  // State register and error flag.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and error-flag decode.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_err_nxt = 1'b0;
          case (cmd_op)
            OP_LOAD, OP_AND, OP_OR: w_state_nxt = S_EXEC;
            OP_SHR, OP_SHL: begin
              if (cmd_count != CNT_ZERO) begin
                w_state_nxt = S_SHIFT;
              end else begin
                w_state_nxt = S_DONE;
              end
            end
            OP_NOP: w_state_nxt = S_DONE;
            default: begin
              w_state_nxt = S_DONE;
              w_err_nxt   = 1'b1;
            end
          endcase
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: w_state_nxt = S_DONE;
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command fields are latched on accept; SHIFT consumes shreg LSB-first.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_op    <= 3'b000;
      r_data  <= '0;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_op    <= cmd_op;
      r_data  <= cmd_data;
      r_shreg <= cmd_ser;
      r_cnt   <= w_count_clamp;
    end else if (r_state == S_SHIFT) begin
      r_shreg <= r_shreg >> 1;
      r_cnt   <= r_cnt - CNT_ONE;
    end else begin
      r_shreg <= r_shreg;
      r_cnt   <= r_cnt;
    end
  end

  // Moore output decode; mode stays 000 outside EXEC/SHIFT so the register holds.
  always_comb begin
    cmd_ready = 1'b0;
    mode      = 3'b000;
    D         = '0;
    Ser       = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (r_state)
      S_IDLE: cmd_ready = 1'b1;
      S_EXEC: begin
        mode = r_op;
        D    = r_data;
      end
      S_SHIFT: begin
        mode = r_op;
        Ser  = r_shreg[0];
      end
      S_DONE: begin
        done = 1'b1;
        err  = r_err;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule
